// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache between the MEM stage and a line-wide memory.
// Hits finish in the request cycle; misses stall the pipeline while a Moore FSM runs writeback/allocate.
module dcache_controller #(
    parameter int INDEX_BITS = 5,
    parameter int LINE_BITS  = 256,
    parameter int TAG_BITS   = 32 - INDEX_BITS - 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          p_addr_i,
    input  logic [31:0]          p_data_i,
    input  logic                 p_MemRead_i,
    input  logic                 p_MemWrite_i,
    output logic [31:0]          p_data_o,
    output logic                 p_stall_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i
);

    localparam int LINES = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    state_t                state_q;
    logic [LINES-1:0]      valid_q;
    logic [LINES-1:0]      dirty_q;
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [LINE_BITS-1:0]  line_q [LINES];
    logic [TAG_BITS-1:0]   miss_tag_q;
    logic [INDEX_BITS-1:0] miss_idx_q;
    logic [31:0]           rdata_q;
    logic [31:0]           mem_addr_q;
    logic [LINE_BITS-1:0]  mem_data_q;

    logic [INDEX_BITS-1:0] idx_s;
    logic [TAG_BITS-1:0]   tag_s;
    logic [2:0]            word_s;
    logic                  req_s;
    logic                  hit_s;
    logic                  idle_s;
    logic                  hit_acc_s;
    logic                  hit_wr_s;
    logic                  fill_s;
    logic [31:0]           hit_word_s;
    logic [LINE_BITS-1:0]  merged_line_d;
    logic                  unused_addr_s;

    assign idx_s         = p_addr_i[INDEX_BITS+4:5];
    assign tag_s         = p_addr_i[31:INDEX_BITS+5];
    assign word_s        = p_addr_i[4:2];
    assign unused_addr_s = ^p_addr_i[1:0];

    assign req_s      = p_MemRead_i | p_MemWrite_i;
    assign hit_s      = valid_q[idx_s] & (tag_q[idx_s] == tag_s);
    assign idle_s     = (state_q == IDLE);
    assign hit_acc_s  = idle_s & req_s & hit_s;
    assign hit_wr_s   = hit_acc_s & p_MemWrite_i;
    assign fill_s     = (state_q == ALLOCATE) & mem_ack_i;
    assign hit_word_s = line_q[idx_s][{word_s, 5'd0} +: 32];

    // Store word merged into the resident line; write-only hits leave other words untouched.
    always_comb begin
        merged_line_d = line_q[idx_s];
        merged_line_d[{word_s, 5'd0} +: 32] = p_data_i;
    end

    // Stall is gated by reset so it drops the instant reset is asserted, even with a request held.
    assign p_stall_o    = ~rst_i & (~idle_s | (req_s & ~hit_s));
    assign p_data_o     = (hit_acc_s & p_MemRead_i) ? hit_word_s : rdata_q;
    assign mem_enable_o = (state_q != IDLE);
    assign mem_write_o  = (state_q == WRITEBACK);
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;

    // FSM, line status bits, miss bookkeeping and registered memory-side request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            dirty_q    <= '0;
            miss_tag_q <= '0;
            miss_idx_q <= '0;
            rdata_q    <= 32'd0;
            mem_addr_q <= 32'd0;
            mem_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_s) begin
                        if (hit_s) begin
                            if (p_MemWrite_i) begin
                                dirty_q[idx_s] <= 1'b1;
                            end
                            if (p_MemRead_i) begin
                                rdata_q <= hit_word_s;
                            end
                        end else begin
                            miss_tag_q <= tag_s;
                            miss_idx_q <= idx_s;
                            if (valid_q[idx_s] & dirty_q[idx_s]) begin
                                state_q    <= WRITEBACK;
                                mem_addr_q <= {tag_q[idx_s], idx_s, 5'b0};
                                mem_data_q <= line_q[idx_s];
                            end else begin
                                state_q    <= ALLOCATE;
                                mem_addr_q <= {tag_s, idx_s, 5'b0};
                            end
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) begin
                        state_q    <= ALLOCATE;
                        mem_addr_q <= {miss_tag_q, miss_idx_q, 5'b0};
                    end
                end
                ALLOCATE: begin
                    if (mem_ack_i) begin
                        state_q             <= IDLE;
                        valid_q[miss_idx_q] <= 1'b1;
                        dirty_q[miss_idx_q] <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Tag and data storage: written by store hits and by line fills only.
    always_ff @(posedge clk_i) begin
        if (hit_wr_s) begin
            line_q[idx_s] <= merged_line_d;
        end else if (fill_s) begin
            line_q[miss_idx_q] <= mem_data_i;
            tag_q[miss_idx_q]  <= miss_tag_q;
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller: directed requests push expected load data and
// memory transactions; monitors pop and compare; a latency-programmable memory model answers.
module tb_dcache_controller;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic [31:0]  p_addr_i = 32'd0;
    logic [31:0]  p_data_i = 32'd0;
    logic         p_MemRead_i = 1'b0;
    logic         p_MemWrite_i = 1'b0;
    logic [31:0]  p_data_o;
    logic         p_stall_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [255:0] mem_data_i = '0;
    logic         mem_ack_i = 1'b0;

    dcache_controller dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .p_addr_i(p_addr_i), .p_data_i(p_data_i),
        .p_MemRead_i(p_MemRead_i), .p_MemWrite_i(p_MemWrite_i),
        .p_data_o(p_data_o), .p_stall_o(p_stall_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] w0;
        logic [31:0] w1;
    } mexp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          lat      = 3;
    int          stall_n;
    logic [31:0] exp_load [$];
    mexp_t       exp_mem  [$];
    logic [255:0] mem_lines [logic [31:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Untouched memory line: each word holds its own byte address.
    function automatic logic [255:0] dflt_line(input logic [31:0] a);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = a + 32'(w * 4);
        return l;
    endfunction

    function automatic logic [255:0] line_of(input logic [31:0] a);
        if (mem_lines.exists(a)) return mem_lines[a];
        return dflt_line(a);
    endfunction

    function automatic mexp_t mk(input logic wr, input logic [31:0] a, w0, w1);
        mexp_t m;
        m.wr = wr; m.addr = a; m.w0 = w0; m.w1 = w1;
        return m;
    endfunction

    // Memory model: acks `lat` cycles into each transaction, one-cycle ack pulse.
    initial begin
        int cnt = 0;
        forever begin
            @(posedge clk_i);
            #2;
            if (rst_i || mem_ack_i) begin
                mem_ack_i = 1'b0;
                cnt = 0;
            end else if (mem_enable_o) begin
                cnt++;
                if (cnt >= lat) begin
                    if (mem_write_o) mem_lines[mem_addr_o] = mem_data_o;
                    else mem_data_i = line_of(mem_addr_o);
                    mem_ack_i = 1'b1;
                end
            end
        end
    end

    // Load monitor: an unstalled read cycle is a completed load.
    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_i && p_MemRead_i && !p_stall_o) begin
                if (exp_load.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_load: got %h expected none", p_data_o);
                end else begin
                    chk("load_data", p_data_o, exp_load.pop_front());
                end
            end
        end
    end

    // Memory monitor: first cycle of each transaction compares direction, address and line words.
    initial begin
        logic prev_en = 1'b0;
        logic prev_ack = 1'b0;
        mexp_t m;
        forever begin
            @(negedge clk_i);
            if (mem_enable_o && (!prev_en || prev_ack)) begin
                if (exp_mem.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_mem_txn: got addr %h write %0d expected none", mem_addr_o, mem_write_o);
                end else begin
                    m = exp_mem.pop_front();
                    chk("mem_write", {31'd0, mem_write_o}, {31'd0, m.wr});
                    chk("mem_addr", mem_addr_o, m.addr);
                    if (m.wr) begin
                        chk("wb_word0", mem_data_o[31:0], m.w0);
                        chk("wb_word1", mem_data_o[63:32], m.w1);
                    end
                end
            end
            prev_en  = mem_enable_o;
            prev_ack = mem_ack_i;
        end
    end

    // One CPU request held until the cycle it is accepted; returns the stalled cycle count.
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic exp_miss, output int n);
        @(posedge clk_i);
        #1;
        p_addr_i = addr; p_data_i = data; p_MemRead_i = rd; p_MemWrite_i = wr;
        @(negedge clk_i);
        chk("stall_first_cycle", {31'd0, p_stall_o}, {31'd0, exp_miss});
        n = 0;
        while (p_stall_o && n < 200) begin
            n++;
            @(negedge clk_i);
        end
        if (p_stall_o) begin
            n_checks++; n_fail++;
            $display("FAIL stall_timeout: got stall after %0d cycles expected release", n);
        end
        @(posedge clk_i);
        #1;
        p_MemRead_i = 1'b0; p_MemWrite_i = 1'b0;
    endtask

    initial begin
        logic [255:0] seed;
        seed = dflt_line(32'h40);
        seed[31:0] = 32'hDEADBEEF;
        mem_lines[32'h40] = seed;

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_stall", {31'd0, p_stall_o}, 32'd0);
        chk("rst_pdata", p_data_o, 32'd0);
        chk("rst_enable", {31'd0, mem_enable_o}, 32'd0);
        chk("rst_write", {31'd0, mem_write_o}, 32'd0);
        chk("rst_maddr", mem_addr_o, 32'd0);
        chk("rst_mdata_zero", {31'd0, (mem_data_o == '0)}, 32'd1);
        rst_i = 1'b0;

        // 1-2: cold read miss, slow memory
        lat = 10;
        exp_mem.push_back(mk(1'b0, 32'h40, 32'd0, 32'd0));
        exp_load.push_back(32'hDEADBEEF);
        do_req(1'b1, 1'b0, 32'h40, 32'd0, 1'b1, stall_n);
        chk("miss_stall_cycles", 32'(stall_n), 32'd11);
        lat = 3;

        // 3: store hit then load hit, zero stall
        do_req(1'b0, 1'b1, 32'h44, 32'h5, 1'b0, stall_n);
        chk("store_hit_stall", 32'(stall_n), 32'd0);
        exp_load.push_back(32'h5);
        do_req(1'b1, 1'b0, 32'h44, 32'd0, 1'b0, stall_n);
        @(negedge clk_i);
        chk("data_hold_idle", p_data_o, 32'h5);

        // 4-5: conflict on dirty index 2 -> writeback then allocate
        exp_mem.push_back(mk(1'b1, 32'h40, 32'hDEADBEEF, 32'h5));
        exp_mem.push_back(mk(1'b0, 32'h440, 32'd0, 32'd0));
        exp_load.push_back(32'h440);
        do_req(1'b1, 1'b0, 32'h440, 32'd0, 1'b1, stall_n);
        chk("wb_alloc_stall_cycles", 32'(stall_n), 32'd8);

        // 6: store miss on cold index 4 -> allocate only, word merged
        exp_mem.push_back(mk(1'b0, 32'h80, 32'd0, 32'd0));
        do_req(1'b0, 1'b1, 32'h80, 32'h12345678, 1'b1, stall_n);
        exp_load.push_back(32'h12345678);
        do_req(1'b1, 1'b0, 32'h80, 32'd0, 1'b0, stall_n);

        // 7: evict the dirty line from scenario 6
        exp_mem.push_back(mk(1'b1, 32'h80, 32'h12345678, 32'h84));
        exp_mem.push_back(mk(1'b0, 32'h480, 32'd0, 32'd0));
        exp_load.push_back(32'h480);
        do_req(1'b1, 1'b0, 32'h480, 32'd0, 1'b1, stall_n);

        // Read and write together: store, returning the pre-write word
        exp_load.push_back(32'h480);
        do_req(1'b1, 1'b1, 32'h480, 32'hAAAAAAAA, 1'b0, stall_n);
        exp_load.push_back(32'hAAAAAAAA);
        do_req(1'b1, 1'b0, 32'h480, 32'd0, 1'b0, stall_n);
        exp_load.push_back(32'h49C);
        do_req(1'b1, 1'b0, 32'h49C, 32'd0, 1'b0, stall_n);

        // 8: reset three cycles into ALLOCATE, request still held
        lat = 20;
        exp_mem.push_back(mk(1'b0, 32'h40, 32'd0, 32'd0));
        @(posedge clk_i);
        #1;
        p_addr_i = 32'h40; p_MemRead_i = 1'b1;
        @(negedge clk_i);
        chk("r8_stall_first", {31'd0, p_stall_o}, 32'd1);
        repeat (3) @(posedge clk_i);
        #1;
        chk("r8_in_allocate", {31'd0, mem_enable_o}, 32'd1);
        rst_i = 1'b1;
        #1;
        chk("r8_async_enable", {31'd0, mem_enable_o}, 32'd0);
        chk("r8_async_stall", {31'd0, p_stall_o}, 32'd0);
        chk("r8_async_pdata", p_data_o, 32'd0);
        p_MemRead_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        lat = 3;
        exp_mem.push_back(mk(1'b0, 32'h40, 32'd0, 32'd0));
        exp_load.push_back(32'hDEADBEEF);
        do_req(1'b1, 1'b0, 32'h40, 32'd0, 1'b1, stall_n);
        exp_load.push_back(32'h5);
        do_req(1'b1, 1'b0, 32'h44, 32'd0, 1'b0, stall_n);

        repeat (5) @(posedge clk_i);
        chk("loads_outstanding", 32'(exp_load.size()), 32'd0);
        chk("mem_txns_outstanding", 32'(exp_mem.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache between the pipeline's MEM stage and a slow line-wide data memory.
- CPU side uses the same MemRead/MemWrite/addr/data signalling the EX_MEM register drives today.
- Hits complete with zero added latency.
- Misses raise a stall that the pipeline uses to freeze PC, IF_ID, ID_EX, EX_MEM and MEM_WB until the line is resident.

Parameters:
INDEX_BITS, 5, log2 of number of lines (32 lines)
LINE_BITS, 256, line width in bits (8 words, 32 bytes; offset = addr[4:0], word select = addr[4:2])
TAG_BITS, 22, 32 - INDEX_BITS - 5; tag = addr[31:INDEX_BITS+5]

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous reset, active-high
p_addr_i  input  32  CPU byte address (word-aligned; addr[1:0] ignored)
p_data_i  input  32  CPU write data
p_MemRead_i  input  1  CPU load request
p_MemWrite_i  input  1  CPU store request
p_data_o  output  32  load data
p_stall_o  output  1  freeze pipeline
mem_addr_o  output  32  line address to memory, low 5 bits always 0
mem_data_o  output  LINE_BITS  line write data
mem_enable_o  output  1  memory transaction active
mem_write_o  output  1  1 = write line, 0 = read line
mem_data_i  input  LINE_BITS  line read data
mem_ack_i  input  1  memory completes the current transaction this cycle

Behaviour:
- Reset (async, rst_i=1): all valid and dirty bits cleared; state=IDLE. All outputs 0: p_stall_o, p_data_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o.
- Reset mid-transaction aborts it. mem_enable_o drops immediately on reset assertion, not at a clock edge. Tag and data arrays need no reset.
- req = p_MemRead_i | p_MemWrite_i.
- hit = valid[idx] & (tag[idx] == addr tag).
- FSM states: IDLE, WRITEBACK, ALLOCATE. The mem_* outputs are decoded from the state register only (Moore).
- IDLE:
  - req & hit:
    - p_stall_o=0.
    - Read: p_data_o = word[addr[4:2]] of the line, combinational, same cycle.
    - Write: on the clock edge, write the selected word and set dirty[idx].
  - req & miss: p_stall_o=1 combinationally in the same cycle.
    - Next state is WRITEBACK if valid[idx] & dirty[idx], else ALLOCATE.
    - The victim tag and line are latched for WRITEBACK.
  - No req: p_stall_o=0, p_data_o holds its last value.
- WRITEBACK:
  - mem_enable_o=1, mem_write_o=1.
  - mem_addr_o = {victim tag, idx, 5'b0}; mem_data_o = victim line.
  - Outputs are held stable until mem_ack_i; on ack, go to ALLOCATE.
  - p_stall_o=1.
- ALLOCATE:
  - mem_enable_o=1, mem_write_o=0, mem_addr_o = {req tag, idx, 5'b0}.
  - On mem_ack_i: capture mem_data_i into the line, set tag, valid=1, dirty=0, go to IDLE.
  - p_stall_o=1.
- Miss latency: the request is re-evaluated in IDLE on the cycle after the ALLOCATE ack and hits. p_stall_o is therefore first 0 one cycle after the ack.
  - Store miss: the store word is merged on that hit cycle, and the line becomes dirty.
- mem_ack_i is ignored in IDLE. The memory must not ack before seeing mem_enable_o=1.
- The CPU holds p_addr_i, p_data_i and the request bits stable while p_stall_o=1.
  - If the request is withdrawn mid-miss, the FSM still completes the current transaction and returns to IDLE.
- p_MemRead_i and p_MemWrite_i both high: treated as a store. p_data_o returns the pre-write word.
- Index wrap: addresses differing only above bit INDEX_BITS+4 conflict on the same line. Only tag compare distinguishes them.
- Outside WRITEBACK, mem_data_o holds its last value. Outside any transaction, mem_addr_o holds its last value.

Test Plan:
1. Reset, then read 0x0000_0040 -> p_stall_o=1 in the same cycle; ALLOCATE with mem_addr_o=0x40, mem_write_o=0.
2. Continue scenario 1: ack after 10 cycles with mem_data_i word0=0xDEADBEEF -> p_stall_o=0 the next cycle and p_data_o=0xDEADBEEF; no WRITEBACK occurs.
3. Store 0x0000_0005 to 0x44 (hit) -> no stall; a following load of 0x44 returns 0x5 with zero stall cycles.
4. Load 0x440 (index 2 conflict, dirty) -> WRITEBACK with mem_addr_o=0x40, mem_write_o=1, mem_data_o word1=0x5, word0=0xDEADBEEF.
5. Continue scenario 4: after ack -> ALLOCATE with mem_addr_o=0x440; after its ack the load returns the new word0.
6. Store 0x1234_5678 to 0x80 on a cold cache -> ALLOCATE only (mem_addr_o=0x80); after ack the word is merged, and a load of 0x80 returns 0x1234_5678.
7. Later eviction of the line from scenario 6 by a load of 0x480 -> WRITEBACK of 0x80 with word0=0x1234_5678.
8. Assert rst_i 3 cycles into ALLOCATE -> mem_enable_o=0 and p_stall_o=0 immediately (asynchronous). After release, a load of 0x40 misses again (valid cleared) and ALLOCATE restarts with mem_addr_o=0x40.
